// File: rtl/snn_pkg.sv
// snn_pkg
// Shared sizes, the scan FSM state type and a small helper for the neuron
// scan controller and its potential register file.
//   NUM_NEURONS : neurons per core (one connectivity bit each)
//   IDX_W       : neuron index width
//   POT_W       : membrane potential width
//   AXON_W      : axon index width (connectivity row address)
//   WTYPE_W     : axon weight-type width
package snn_pkg;
    localparam int NUM_NEURONS = 32;
    localparam int IDX_W       = 5;
    localparam int POT_W       = 8;
    localparam int AXON_W      = 8;
    localparam int WTYPE_W     = 2;
    localparam int ROW_W       = NUM_NEURONS;
    localparam int WSEL_W      = 8;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SCAN,
        ST_DONE
    } state_e;

    // The neuron_block parameter mux takes an 8-bit select; only the low
    // bits carry the axon weight type.
    function automatic logic [WSEL_W-1:0] weight_select(input logic [WTYPE_W-1:0] wtype);
        return {{(WSEL_W - WTYPE_W){1'b0}}, wtype};
    endfunction
endpackage

// File: rtl/neuron_scan_controller_if.sv
// neuron_scan_controller_if
// Bundles every non-clock/reset signal of the neuron scan controller.
//   axon_*        : incoming axon event (valid/ready handshake)
//   conn_*        : connectivity-row read (strobe, address, returned row)
//   nb_*          : connection to the external neuron_block
//   spike_*       : outgoing spike event (valid/ready handshake)
//   pot_rd_*      : debug read of one neuron potential
//   busy_o/done_o : status
// Modports: slave = the controller, master = its surroundings.
interface neuron_scan_controller_if;
    import snn_pkg::*;

    logic                axon_valid_i;
    logic [AXON_W-1:0]   axon_id_i;
    logic [WTYPE_W-1:0]  axon_type_i;
    logic                axon_ready_o;

    logic                conn_rd_o;
    logic [AXON_W-1:0]   conn_addr_o;
    logic [ROW_W-1:0]    conn_data_i;

    logic [IDX_W-1:0]    nb_idx_o;
    logic [POT_W-1:0]    nb_voltage_o;
    logic [WSEL_W-1:0]   nb_weight_select_o;
    logic                nb_enable_o;
    logic [POT_W-1:0]    nb_new_potential_i;
    logic                nb_spike_i;

    logic                spike_valid_o;
    logic [IDX_W-1:0]    spike_id_o;
    logic                spike_ready_i;

    logic [IDX_W-1:0]    pot_rd_idx_i;
    logic [POT_W-1:0]    pot_rd_data_o;

    logic                busy_o;
    logic                done_o;

    modport slave (
        input  axon_valid_i, axon_id_i, axon_type_i,
        output axon_ready_o,
        output conn_rd_o, conn_addr_o,
        input  conn_data_i,
        output nb_idx_o, nb_voltage_o, nb_weight_select_o, nb_enable_o,
        input  nb_new_potential_i, nb_spike_i,
        output spike_valid_o, spike_id_o,
        input  spike_ready_i,
        input  pot_rd_idx_i,
        output pot_rd_data_o,
        output busy_o, done_o
    );

    modport master (
        output axon_valid_i, axon_id_i, axon_type_i,
        input  axon_ready_o,
        input  conn_rd_o, conn_addr_o,
        output conn_data_i,
        input  nb_idx_o, nb_voltage_o, nb_weight_select_o, nb_enable_o,
        output nb_new_potential_i, nb_spike_i,
        input  spike_valid_o, spike_id_o,
        output spike_ready_i,
        output pot_rd_idx_i,
        input  pot_rd_data_o,
        input  busy_o, done_o
    );
endinterface

// File: rtl/potential_regfile.sv
// potential_regfile
// Holds the NUM_NEURONS membrane potentials. One synchronous write port and
// two combinational read ports (port A follows the scan index, port B is the
// debug read). Asynchronous active-low reset clears every potential.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   we_i/waddr_i/wdata_i : write port
//   raddr_a_i/rdata_a_o  : scan read port
//   raddr_b_i/rdata_b_o  : debug read port
module potential_regfile
    import snn_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [POT_W-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_a_i,
    output logic [POT_W-1:0] rdata_a_o,
    input  logic [IDX_W-1:0] raddr_b_i,
    output logic [POT_W-1:0] rdata_b_o
);
    logic [POT_W-1:0]       r_pot [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] w_we;

    // One-hot write decode per entry.
    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_we
        assign w_we[gi] = we_i && (waddr_i == IDX_W'(gi));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_pot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (w_we[i]) begin
                    r_pot[i] <= wdata_i;
                end
            end
        end
    end

    assign rdata_a_o = r_pot[raddr_a_i];
    assign rdata_b_o = r_pot[raddr_b_i];
endmodule

// File: rtl/neuron_scan_controller.sv
// neuron_scan_controller
// Accepts one axon event at a time, reads that axon's 32-bit connectivity
// row, then walks neurons 0..31 driving the external neuron_block for every
// connected neuron and writing its result back. Spikes are offered on a
// valid/ready port; while a spike waits for ready the scan freezes.
//   clk_i  : core clock
//   rst_ni : asynchronous active-low reset
//   bus    : neuron_scan_controller_if.slave (axon in, row read,
//            neuron_block, spike out, debug read, busy/done)
module neuron_scan_controller
    import snn_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    neuron_scan_controller_if.slave   bus
);
    state_e             r_state;
    state_e             w_state_next;

    logic [AXON_W-1:0]  r_axon_id;
    logic [WTYPE_W-1:0] r_axon_type;
    logic [ROW_W-1:0]   r_row;
    logic [IDX_W-1:0]   r_idx;
    logic               r_spike_valid;
    logic [IDX_W-1:0]   r_spike_id;

    logic               w_accept;
    logic               w_stalled;
    logic               w_scan_step;
    logic               w_enable;
    logic               w_last;
    logic [POT_W-1:0]   w_scan_pot;
    logic [POT_W-1:0]   w_dbg_pot;

    // A spike still waiting for ready freezes the scan; a ready in the same
    // cycle frees it, so the next neuron can be processed without a bubble.
    assign w_stalled   = r_spike_valid && !bus.spike_ready_i;
    assign w_accept    = (r_state == ST_IDLE) && bus.axon_valid_i;
    assign w_scan_step = (r_state == ST_SCAN) && !w_stalled;
    assign w_enable    = w_scan_step && r_row[r_idx];
    assign w_last      = (r_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_FETCH;
            ST_FETCH: w_state_next = ST_SCAN;
            ST_SCAN:  if (w_scan_step && w_last) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        bus.axon_ready_o = 1'b0;
        bus.conn_rd_o    = 1'b0;
        bus.done_o       = 1'b0;
        bus.busy_o       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                bus.axon_ready_o = 1'b1;
                bus.busy_o       = 1'b0;
            end
            ST_FETCH: bus.conn_rd_o = 1'b1;
            ST_DONE:  bus.done_o    = 1'b1;
            default: ;
        endcase
    end

    // Event latch, row, scan index and spike register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_axon_id     <= '0;
            r_axon_type   <= '0;
            r_row         <= '0;
            r_idx         <= '0;
            r_spike_valid <= 1'b0;
            r_spike_id    <= '0;
        end else begin
            if (w_accept) begin
                r_axon_id   <= bus.axon_id_i;
                r_axon_type <= bus.axon_type_i;
            end

            // Index saturates at the last neuron; FETCH restarts it.
            if (r_state == ST_FETCH) begin
                r_row <= bus.conn_data_i;
                r_idx <= '0;
            end else if (w_scan_step && !w_last) begin
                r_idx <= r_idx + IDX_W'(1);
            end

            if (w_enable && bus.nb_spike_i) begin
                r_spike_valid <= 1'b1;
                r_spike_id    <= r_idx;
            end else if (r_spike_valid && bus.spike_ready_i) begin
                r_spike_valid <= 1'b0;
            end
        end
    end

    // Only enabled cycles write: a disabled neuron_block outputs zero.
    potential_regfile u_potential_regfile (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .we_i      (w_enable),
        .waddr_i   (r_idx),
        .wdata_i   (bus.nb_new_potential_i),
        .raddr_a_i (r_idx),
        .rdata_a_o (w_scan_pot),
        .raddr_b_i (bus.pot_rd_idx_i),
        .rdata_b_o (w_dbg_pot)
    );

    assign bus.conn_addr_o        = r_axon_id;
    assign bus.nb_idx_o           = r_idx;
    assign bus.nb_voltage_o       = w_scan_pot;
    assign bus.nb_weight_select_o = weight_select(r_axon_type);
    assign bus.nb_enable_o        = w_enable;
    assign bus.spike_valid_o      = r_spike_valid;
    assign bus.spike_id_o         = r_spike_id;
    assign bus.pot_rd_data_o      = w_dbg_pot;
endmodule

// File: doc/neuron_scan_controller.md
NEURON_SCAN_CONTROLLER -- requirements
Module: neuron_scan_controller

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset; no other clock or reset input.
REQ-002 clk_i  in  1  core clock; all state changes on the rising edge.
REQ-003 rst_ni  in  1  asynchronous active-low reset.
REQ-004 axon_valid_i  in  1  incoming axon event valid.
REQ-005 axon_id_i  in  8  axon index, 0..255.
REQ-006 axon_type_i  in  2  weight type of the axon, 0..3.
REQ-007 axon_ready_o  out  1  high only in IDLE; an event is accepted when axon_valid_i and axon_ready_o are both high.
REQ-008 conn_rd_o  out  1  connectivity-row read strobe.
REQ-009 conn_addr_o  out  8  row address, equal to the latched axon_id.
REQ-010 conn_data_i  in  32  connection row; bit n means neuron n is connected; valid one cycle after conn_rd_o.
REQ-011 nb_idx_o  out  5  neuron index presented to the neuron_block parameter mux.
REQ-012 nb_voltage_o  out  8  potential of neuron nb_idx_o.
REQ-013 nb_weight_select_o  out  8  {6'b0, latched axon_type}.
REQ-014 nb_enable_o  out  1  neuron_block enable.
REQ-015 nb_new_potential_i  in  8  combinational neuron_block result.
REQ-016 nb_spike_i  in  1  combinational neuron_block spike.
REQ-017 spike_valid_o  out  1  spike event pending.
REQ-018 spike_id_o  out  5  index of the spiking neuron.
REQ-019 spike_ready_i  in  1  downstream accepts the spike.
REQ-020 pot_rd_idx_i  in  5  debug read index.
REQ-021 pot_rd_data_o  out  8  combinational potential[pot_rd_idx_i].
REQ-022 busy_o  out  1  high whenever the state is not IDLE.
REQ-023 done_o  out  1  one-cycle pulse at the end of a scan.

Function
REQ-024 The block SHALL hold 32 x 8-bit neuron potentials internally.
REQ-025 The FSM SHALL have the states IDLE, FETCH, SCAN and DONE.
REQ-026 IDLE->FETCH on accept: latch axon_id and axon_type; raise conn_rd_o for exactly the one FETCH cycle.
REQ-027 FETCH->SCAN: register conn_data_i as the row and set idx=0.
REQ-028 SCAN visits idx 0..31 in order, one neuron per cycle unless stalled.
REQ-029 nb_enable_o = row[idx] AND not stalled.
REQ-030 In an enabled cycle, potential[idx] SHALL take nb_new_potential_i at the clock edge.
REQ-031 An unconnected neuron SHALL keep its potential; neuron_block zeroes its output when disabled, so that output must not be written.
REQ-032 If nb_spike_i is high in an enabled cycle, the block SHALL register spike_valid_o=1 and spike_id_o=idx.
REQ-033 Stall: while spike_valid_o=1 and spike_ready_i=0, idx, the potentials and the row SHALL hold.
REQ-034 A spike SHALL clear on handshake; a same-cycle ready plus new spike SHALL reload it without a bubble.
REQ-035 idx=31 advancing SHALL go to DONE; DONE pulses done_o and returns to IDLE.
REQ-036 Unstalled latency from accept to done_o is 34 cycles, and the next accept is possible on the following cycle.
REQ-037 A row of all zeros SHALL still take 32 SCAN cycles and produce no writes and no spikes.
REQ-038 A pending spike MAY persist into IDLE; a new event SHALL still be accepted while it is pending.
REQ-039 The index counter SHALL NOT wrap back to 0 within a scan.

Reset
REQ-040 Asserting rst_ni at any time, including mid-scan, SHALL immediately force IDLE, all potentials=0, row=0, idx=0, spike_valid_o=0, spike_id_o=0, conn_rd_o=0, done_o=0 and busy_o=0.
REQ-041 Release is synchronous to clk_i; axon_ready_o=1 on the first cycle after release.

Structure
REQ-042 Shared package snn_pkg SHALL hold NUM_NEURONS=32, the widths IDX_W=5, POT_W=8, AXON_W=8 and WTYPE_W=2, and the state enum.
REQ-043 The potential array SHALL be the sub-module potential_regfile: one write port, two combinational read ports (scan and debug).
REQ-044 neuron_block SHALL be instantiated outside this block; the bench wires them together.

Verification
Neuron-block parameters for every scenario: pos_threshold=252, neg_threshold=0, leak=15, pos_reset=3, neg_reset=0.
REQ-045 Reset, then axon 5, type 0, row 0x00000001, weight1=100 -> conn_addr_o=5; pot[0]=85, no spike, done_o 34 cycles after accept.
REQ-046 Repeat that event twice more -> pot[0]=170, then 255>=252 -> spike_id_o=0 and pot[0]=3.
REQ-047 Row 0x80000000, pot[31]=250, type 3, weight4=20 -> spike on the idx=31 cycle, spike_id_o=31, pot[31]=3, done_o follows.
REQ-048 Row 0x00000003, both neurons spiking, spike_ready_i held 0 for 5 cycles -> scan stalls at idx 1; spike 0 then spike 1 delivered in order; done_o at 39 cycles.
REQ-049 Row 0x00000000 -> no nb_enable_o and no spike; all potentials unchanged; done_o at 34.
REQ-050 rst_ni pulsed low mid-scan at idx 10 -> outputs and potentials 0 at once; a new event is accepted on the first cycle after release.
